// File: rtl/wb_trace_buffer_pkg.sv
// Shared trace-entry layout for the writeback trace buffer.
// An entry packs {pc, data}; offsets below locate each field.
package wb_trace_buffer_pkg;

  localparam int TRACE_ENTRY_W = 64;
  localparam int PC_HI         = 63;
  localparam int PC_LO         = 32;
  localparam int DATA_HI       = 31;
  localparam int DATA_LO       = 0;

endpackage

// File: rtl/wb_trace_buffer_halt_detector.sv
// Halt detector: flags when wb_pc holds still for HALT_CYCLES cycles.
// Ports: Clk, Reset (sync, high), wb_pc in; halted (sticky) out.
module wb_halt_detector #(
  parameter int HALT_CYCLES = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] wb_pc,
  output logic        halted
);

  localparam int HCW = $clog2(HALT_CYCLES + 1);

  logic [31:0]    pc_q;
  logic [HCW-1:0] hcnt;
  logic           match;

  assign match = (wb_pc == pc_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q   <= '0;
      hcnt   <= '0;
      halted <= 1'b0;
    end else begin
      pc_q <= wb_pc;
      if (match) begin
        if (hcnt != HCW'(HALT_CYCLES))
          hcnt <= hcnt + HCW'(1);
        // count already covers HALT_CYCLES-1 repeats; this one completes it
        if (hcnt >= HCW'(HALT_CYCLES - 1))
          halted <= 1'b1;
      end else begin
        hcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace FIFO: captures {pc, data} per retired writeback.
// Ports: Clk, Reset, wb_valid/wb_pc/wb_data in; rd_* FWFT read side,
// count, overflow_cnt (saturating), halted out.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int OVF_W          = 8,
  parameter int HALT_CYCLES    = 64,
  parameter int FREEZE_ON_HALT = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     wb_valid,
  input  logic [31:0]              wb_pc,
  input  logic [31:0]              wb_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [OVF_W-1:0]         overflow_cnt,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);

  logic [TRACE_ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]              wr_ptr;
  logic [AW:0]              rd_ptr;
  logic [TRACE_ENTRY_W-1:0] head;
  logic                     empty;
  logic                     full;
  logic                     frozen;
  logic                     cap;
  logic                     pop;
  logic                     push;

  wb_halt_detector #(
    .HALT_CYCLES(HALT_CYCLES)
  ) u_halt (
    .Clk    (Clk),
    .Reset  (Reset),
    .wb_pc  (wb_pc),
    .halted (halted)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);

  assign frozen = (FREEZE_ON_HALT != 0) && halted;
  assign cap    = wb_valid && !frozen;
  assign pop    = rd_valid && rd_ready;
  // a full FIFO still accepts when the head leaves the same cycle
  assign push   = cap && (!full || pop);

  assign rd_valid = !empty;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign rd_pc    = rd_valid ? head[PC_HI:PC_LO] : '0;
  assign rd_data  = rd_valid ? head[DATA_HI:DATA_LO] : '0;
  assign count    = wr_ptr - rd_ptr;

  always_ff @(posedge Clk) begin
    if (!Reset && push)
      mem[wr_ptr[AW-1:0]] <= {wb_pc, wb_data};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      if (cap && full && !pop && (overflow_cnt != '1))
        overflow_cnt <= overflow_cnt + OVF_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer.
// Scoreboard queue models FIFO contents, drops and halt.
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int HALT  = 64;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_data = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_data;
  logic [4:0]  count;
  logic [7:0]  overflow_cnt;
  logic        halted;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_q[$];
  int          m_ovf;
  int          m_hcnt;
  logic [31:0] m_pcq;
  logic        m_halted;

  always #5 clk = ~clk;

  wb_trace_buffer dut (
    .Clk          (clk),
    .Reset        (Reset),
    .wb_valid     (wb_valid),
    .wb_pc        (wb_pc),
    .wb_data      (wb_data),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_pc        (rd_pc),
    .rd_data      (rd_data),
    .count        (count),
    .overflow_cnt (overflow_cnt),
    .halted       (halted)
  );

  task automatic do_reset(input logic v);
    Reset = 1'b1;
    wb_valid = v;
    wb_pc = 32'h55;
    wb_data = 32'h66;
    rd_ready = 1'b1;
    @(posedge clk);
    m_q.delete();
    m_ovf = 0;
    m_hcnt = 0;
    m_pcq = '0;
    m_halted = 1'b0;
    #1;
    Reset = 1'b0;
    wb_valid = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic step(input logic v, input logic [31:0] pc,
                      input logic [31:0] d, input logic rr);
    logic pop_now;
    logic cap;
    wb_valid = v;
    wb_pc = pc;
    wb_data = d;
    rd_ready = rr;
    @(posedge clk);
    pop_now = rr && (m_q.size() != 0);
    cap = v && !m_halted;
    if (pop_now)
      void'(m_q.pop_front());
    if (cap) begin
      if (m_q.size() < DEPTH)
        m_q.push_back({pc, d});
      else if (m_ovf < 255)
        m_ovf++;
    end
    if (pc == m_pcq) begin
      if (m_hcnt >= HALT - 1)
        m_halted = 1'b1;
      if (m_hcnt < HALT)
        m_hcnt++;
    end else begin
      m_hcnt = 0;
    end
    m_pcq = pc;
    #1;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    do_reset(1'b0);
    total++;
    if (rd_valid !== 1'b0 || count !== 5'd0) begin
      bad++;
      $display("FAIL reset_fifo: valid=%b count=%0d want 0 0",
               rd_valid, count);
    end
    total++;
    if (rd_pc !== 32'h0 || rd_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_rd: pc=%h data=%h want 0 0", rd_pc, rd_data);
    end
    total++;
    if (overflow_cnt !== 8'd0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: ovf=%0d halted=%b want 0 0",
               overflow_cnt, halted);
    end
  endtask

  task automatic test_capture;
    do_reset(1'b0);
    step(1'b1, 32'd4, 32'd1, 1'b0);
    total++;
    if (rd_valid !== 1'b1 || rd_pc !== 32'd4 || rd_data !== 32'd1) begin
      bad++;
      $display("FAIL first_capture: v=%b pc=%h data=%h want 1 4 1",
               rd_valid, rd_pc, rd_data);
    end
    step(1'b1, 32'd8, 32'd2, 1'b0);
    step(1'b1, 32'd12, 32'd3, 1'b0);
    total++;
    if (count !== 5'd3) begin
      bad++;
      $display("FAIL capture_count: got %0d want 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (m_q.size() == 0 || rd_pc !== m_q[0][63:32] ||
          rd_data !== m_q[0][31:0]) begin
        bad++;
        $display("FAIL capture_drain%0d: pc=%h data=%h", i, rd_pc, rd_data);
      end
      step(1'b0, 32'h300 + 32'(i), 32'h0, 1'b1);
    end
    total++;
    if (rd_valid !== 1'b0 || rd_pc !== 32'h0) begin
      bad++;
      $display("FAIL drained_empty: v=%b pc=%h want 0 0", rd_valid, rd_pc);
    end
  endtask

  task automatic test_overflow;
    do_reset(1'b0);
    for (int i = 0; i < DEPTH + 2; i++)
      step(1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0);
    total++;
    if (count !== 5'd16 || overflow_cnt !== 8'd2) begin
      bad++;
      $display("FAIL overflow: count=%0d ovf=%0d want 16 2",
               count, overflow_cnt);
    end
    total++;
    if (rd_pc !== 32'h100 || rd_data !== 32'hA000) begin
      bad++;
      $display("FAIL overflow_head: pc=%h data=%h want 100 a000",
               rd_pc, rd_data);
    end
  endtask

  task automatic test_full_push_pop;
    total++;
    if (rd_pc !== m_q[0][63:32]) begin
      bad++;
      $display("FAIL fpp_head_before: got %h want %h", rd_pc, m_q[0][63:32]);
    end
    step(1'b1, 32'h200, 32'hBEEF, 1'b1);
    total++;
    if (count !== 5'd16 || overflow_cnt !== 8'd2) begin
      bad++;
      $display("FAIL fpp_count: count=%0d ovf=%0d want 16 2",
               count, overflow_cnt);
    end
    total++;
    if (rd_pc !== 32'h104 || rd_data !== 32'hA001) begin
      bad++;
      $display("FAIL fpp_head: pc=%h data=%h want 104 a001", rd_pc, rd_data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (m_q.size() == 0 || rd_pc !== m_q[0][63:32] ||
          rd_data !== m_q[0][31:0]) begin
        bad++;
        $display("FAIL fpp_drain%0d: pc=%h data=%h", i, rd_pc, rd_data);
      end
      step(1'b0, 32'h900 + 32'(4 * i), 32'h0, 1'b1);
    end
    total++;
    if (count !== 5'd0 || m_q.size() != 0) begin
      bad++;
      $display("FAIL fpp_empty: count=%0d want 0", count);
    end
  endtask

  task automatic test_halt;
    do_reset(1'b0);
    for (int i = 0; i < HALT; i++)
      step(1'b1, 32'h40, 32'(i), 1'b0);
    total++;
    if (halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_early: got %b want 0", halted);
    end
    step(1'b1, 32'h40, 32'h77, 1'b0);
    total++;
    if (halted !== 1'b1 || halted !== m_halted) begin
      bad++;
      $display("FAIL halt_set: got %b want 1", halted);
    end
    total++;
    if (count !== 5'd16 || overflow_cnt !== 8'd49) begin
      bad++;
      $display("FAIL halt_state: count=%0d ovf=%0d want 16 49",
               count, overflow_cnt);
    end
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h40 + 32'(4 * i), 32'h5, 1'b0);
    total++;
    if (count !== 5'd16 || overflow_cnt !== 8'd49 || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_frozen: count=%0d ovf=%0d h=%b want 16 49 1",
               count, overflow_cnt, halted);
    end
    step(1'b1, 32'h80, 32'h6, 1'b1);
    total++;
    if (count !== 5'd15 || 32'(count) != m_q.size()) begin
      bad++;
      $display("FAIL halt_no_push: count=%0d want 15", count);
    end
  endtask

  task automatic test_toggle;
    do_reset(1'b0);
    for (int i = 0; i < 200; i++) begin
      if (m_q.size() != 0) begin
        total++;
        if (rd_pc !== m_q[0][63:32] || rd_data !== m_q[0][31:0]) begin
          bad++;
          $display("FAIL toggle_head%0d: pc=%h data=%h want %h %h", i,
                   rd_pc, rd_data, m_q[0][63:32], m_q[0][31:0]);
        end
      end
      step(1'b1, (i % 2 == 0) ? 32'h40 : 32'h44, 32'(i), 1'b1);
    end
    total++;
    if (halted !== 1'b0 || count !== 5'd1) begin
      bad++;
      $display("FAIL toggle_end: halted=%b count=%0d want 0 1",
               halted, count);
    end
  endtask

  task automatic test_reset_midstream;
    do_reset(1'b0);
    for (int i = 0; i < DEPTH + 260; i++)
      step(1'b1, 32'h1000 + 32'(4 * i), 32'(i), 1'b0);
    total++;
    if (overflow_cnt !== 8'd255 || m_ovf != 255) begin
      bad++;
      $display("FAIL ovf_saturate: got %0d want 255", overflow_cnt);
    end
    for (int i = 0; i < 11; i++)
      step(1'b0, 32'h2000 + 32'(4 * i), 32'h0, 1'b1);
    total++;
    if (count !== 5'd5) begin
      bad++;
      $display("FAIL pre_reset_count: got %0d want 5", count);
    end
    do_reset(1'b1);
    total++;
    if (rd_valid !== 1'b0 || rd_pc !== 32'h0 || rd_data !== 32'h0 ||
        count !== 5'd0 || overflow_cnt !== 8'd0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL midstream_reset: v=%b pc=%h d=%h c=%0d o=%0d h=%b",
               rd_valid, rd_pc, rd_data, count, overflow_cnt, halted);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_full_push_pop();
    test_halt();
    test_toggle();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
